// File: rtl/suite_result_monitor.sv
// suite_result_monitor: snoops the 6502 bus for result-channel writes and trap loops, reporting PASS, FAIL or TIMEOUT
module suite_result_monitor #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int NUM_CH = 2,
  parameter logic [ADDR_W*NUM_CH-1:0] RES_ADDRS = {16'h0211, 16'h0210},
  parameter logic [DATA_W-1:0] PASS_VAL = 8'hFF,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TRAP_COUNT = 4,
  parameter int CNT_W = 16,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              ph2,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              bus_we,
  input  logic              bus_sync,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CH_W-1:0]   fail_ch,
  output logic [DATA_W-1:0] fail_code,
  output logic [CNT_W-1:0]  cycles
);
  localparam int TC_W = $clog2(TRAP_COUNT + 1);
  typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TOUT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [NUM_CH-1:0][DATA_W-1:0] val_q, val_d;
  logic [NUM_CH-1:0] flag_q, flag_d;
  logic [TC_W-1:0] trap_cnt_q, trap_cnt_d;
  logic [ADDR_W-1:0] sync_addr_q, sync_addr_d;
  logic sync_seen_q, sync_seen_d;
  logic done_q, done_d, pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
  logic [CH_W-1:0] fail_ch_q, fail_ch_d, first_bad;
  logic [DATA_W-1:0] fail_code_q, fail_code_d;
  logic trap, expire;
  always_comb begin
    state_d = state_q;
    cycles_d = cycles_q;
    val_d = val_q;
    flag_d = flag_q;
    trap_cnt_d = trap_cnt_q;
    sync_addr_d = sync_addr_q;
    sync_seen_d = sync_seen_q;
    done_d = done_q;
    pass_d = pass_q;
    fail_d = fail_q;
    timeout_d = timeout_q;
    fail_ch_d = fail_ch_q;
    fail_code_d = fail_code_q;
    first_bad = '0;
    trap = 1'b0;
    expire = 1'b0;
    if (state_q == RUN) begin
      cycles_d = &cycles_q ? cycles_q : cycles_q + 1'b1;
      for (int i = 0; i < NUM_CH; i++)
        if (bus_we && bus_addr == RES_ADDRS[i*ADDR_W +: ADDR_W]) begin
          val_d[i] = bus_data;
          flag_d[i] = bus_data == PASS_VAL;
        end
      // a first sync after start never counts as a repeat, whatever the address
      if (bus_sync) begin
        trap_cnt_d = sync_seen_q && bus_addr == sync_addr_q ?
                     (trap_cnt_q == TC_W'(TRAP_COUNT) ? trap_cnt_q : trap_cnt_q + 1'b1) : TC_W'(1);
        sync_addr_d = bus_addr;
        sync_seen_d = 1'b1;
      end
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (!flag_d[i]) first_bad = CH_W'(i);
      trap = trap_cnt_d == TC_W'(TRAP_COUNT);
      expire = cycles_q == CNT_W'(TIMEOUT_CYC - 1);
      if (&flag_d) begin
        state_d = PASS;
        done_d = 1'b1;
        pass_d = 1'b1;
      end else if (trap || expire) begin
        state_d = trap ? FAIL : TOUT;
        done_d = 1'b1;
        fail_d = trap;
        timeout_d = !trap;
        fail_ch_d = first_bad;
        fail_code_d = val_d[first_bad];
      end
    end else if (start) begin
      state_d = RUN;
      cycles_d = '0;
      val_d = '0;
      flag_d = '0;
      trap_cnt_d = '0;
      sync_addr_d = '0;
      sync_seen_d = 1'b0;
      done_d = 1'b0;
      pass_d = 1'b0;
      fail_d = 1'b0;
      timeout_d = 1'b0;
      fail_ch_d = '0;
      fail_code_d = '0;
    end
  end
  always_ff @(posedge ph2) begin
    if (reset) begin
      state_q <= IDLE;
      cycles_q <= '0;
      val_q <= '0;
      flag_q <= '0;
      trap_cnt_q <= '0;
      sync_addr_q <= '0;
      sync_seen_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      timeout_q <= 1'b0;
      fail_ch_q <= '0;
      fail_code_q <= '0;
    end else begin
      state_q <= state_d;
      cycles_q <= cycles_d;
      val_q <= val_d;
      flag_q <= flag_d;
      trap_cnt_q <= trap_cnt_d;
      sync_addr_q <= sync_addr_d;
      sync_seen_q <= sync_seen_d;
      done_q <= done_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      timeout_q <= timeout_d;
      fail_ch_q <= fail_ch_d;
      fail_code_q <= fail_code_d;
    end
  end
  assign done = done_q;
  assign pass = pass_q;
  assign fail = fail_q;
  assign timeout = timeout_q;
  assign fail_ch = fail_ch_q;
  assign fail_code = fail_code_q;
  assign cycles = cycles_q;
endmodule

// File: tb/tb_suite_result_monitor.sv
// tb_suite_result_monitor: table of bus scenarios with scoreboarded verdicts, plus reset/idle/restart sequences
`timescale 1ns/1ps
module tb_suite_result_monitor;
  logic ph2 = 1'b0, reset = 1'b1, start = 1'b0, bus_we = 1'b0, bus_sync = 1'b0;
  logic [15:0] bus_addr = '0;
  logic [7:0] bus_data = '0;
  logic done, pass, fail, timeout;
  logic [0:0] fail_ch;
  logic [7:0] fail_code;
  logic [15:0] cycles;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [15:0] w0a; logic [7:0] w0d; int w0c;
    logic [15:0] w1a; logic [7:0] w1d; int w1c;
    logic [15:0] w2a; logic [7:0] w2d; int w2c;
    logic [15:0] sa; int sf; int sn; int ss;
    logic [15:0] sa2; int s2c;
    int st;
    logic ep; logic ef; logic et; logic ech; logic [7:0] ecode; int ecyc;
  } vec_t;
  typedef struct { logic p; logic f; logic t; logic ch; logic [7:0] code; int cyc; } res_t;
  vec_t vecs[9];
  res_t sb[$];

  suite_result_monitor #(.TIMEOUT_CYC(1000), .TRAP_COUNT(4)) dut (
    .ph2(ph2), .reset(reset), .start(start), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_we(bus_we), .bus_sync(bus_sync), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .fail_ch(fail_ch), .fail_code(fail_code), .cycles(cycles)
  );

  always #5 ph2 = ~ph2;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  task automatic tick();
    @(posedge ph2);
    #1;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, ".done"}, done, 0);
    check({tag, ".pass"}, pass, 0);
    check({tag, ".fail"}, fail, 0);
    check({tag, ".timeout"}, timeout, 0);
    check({tag, ".fail_ch"}, fail_ch, 0);
    check({tag, ".fail_code"}, fail_code, 0);
    check({tag, ".cycles"}, cycles, 0);
  endtask

  task automatic check_res(string tag, res_t r);
    check({tag, ".done"}, done, 1);
    check({tag, ".pass"}, pass, r.p);
    check({tag, ".fail"}, fail, r.f);
    check({tag, ".timeout"}, timeout, r.t);
    check({tag, ".fail_ch"}, fail_ch, r.ch);
    check({tag, ".fail_code"}, fail_code, r.code);
    check({tag, ".cycles"}, cycles, r.cyc);
  endtask

  task automatic drive(vec_t v, int n);
    bit is_s;
    start = (n == v.st);
    bus_we = 1'($urandom_range(0, 1));
    bus_addr = 16'h0400 | 16'($urandom_range(0, 255));
    bus_data = 8'($urandom);
    bus_sync = 1'b0;
    is_s = v.sn > 0 && n >= v.sf && (n - v.sf) % v.ss == 0 && (n - v.sf) / v.ss < v.sn;
    if (is_s || n == v.s2c) begin
      bus_sync = 1'b1;
      bus_we = 1'b0;
      bus_addr = (n == v.s2c) ? v.sa2 : v.sa;
    end
    if (n == v.w0c) begin bus_we = 1'b1; bus_addr = v.w0a; bus_data = v.w0d; end
    if (n == v.w1c) begin bus_we = 1'b1; bus_addr = v.w1a; bus_data = v.w1d; end
    if (n == v.w2c) begin bus_we = 1'b1; bus_addr = v.w2a; bus_data = v.w2d; end
  endtask

  task automatic run_case(int k);
    vec_t v;
    res_t r;
    int n;
    bit seen;
    string tag;
    v = vecs[k];
    tag = $sformatf("c%0d", k);
    bus_we = 1'b0;
    bus_sync = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back('{v.ep, v.ef, v.et, v.ech, v.ecode, v.ecyc});
    check({tag, ".start_done"}, done, 0);
    check({tag, ".start_cycles"}, cycles, 0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 1100) begin
      n++;
      drive(v, n);
      tick();
      seen = done;
    end
    start = 1'b0;
    bus_we = 1'b0;
    bus_sync = 1'b0;
    check({tag, ".done_seen"}, seen, 1);
    r = sb.pop_front();
    check_res(tag, r);
    repeat (3) begin
      bus_we = 1'b1;
      bus_sync = 1'b1;
      bus_addr = 16'h0210 + 16'($urandom_range(0, 1));
      bus_data = 8'($urandom);
      tick();
    end
    bus_we = 1'b0;
    bus_sync = 1'b0;
    check_res({tag, ".hold"}, r);
  endtask

  initial begin
    vecs[0] = '{16'h0210, 8'h05, 1, 16'h0210, 8'hFF, 2, 16'h0211, 8'hFF, 50,
                16'h0000, 0, 0, 1, 16'h0000, 0, 10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 50};
    vecs[1] = '{16'h0210, 8'hFF, 1, 16'h0211, 8'h2A, 2, 16'h0000, 8'h00, 0,
                16'hF5A4, 5, 4, 1, 16'h0000, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h2A, 8};
    vecs[2] = '{16'h0210, 8'hFF, 1, 16'h0210, 8'h07, 2, 16'h0000, 8'h00, 0,
                16'h0000, 0, 0, 1, 16'h0000, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h07, 1000};
    vecs[3] = '{16'h0210, 8'hFF, 1, 16'h0211, 8'hFF, 8, 16'h0000, 8'h00, 0,
                16'h0211, 5, 4, 1, 16'h0000, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8};
    vecs[4] = '{16'h0210, 8'hFF, 1, 16'h0211, 8'h00, 8, 16'h0000, 8'h00, 0,
                16'h0211, 5, 4, 1, 16'h0000, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8};
    vecs[5] = '{16'h0210, 8'hFF, 1, 16'h0211, 8'hFF, 20, 16'h0000, 8'h00, 0,
                16'hF5A4, 5, 4, 1, 16'hF5A6, 7, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 20};
    vecs[6] = '{16'h0210, 8'hFF, 1, 16'h0000, 8'h00, 0, 16'h0000, 8'h00, 0,
                16'hF5A4, 5, 4, 3, 16'h0000, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 14};
    vecs[7] = '{16'h0210, 8'hFF, 1, 16'h0211, 8'hFF, 1000, 16'h0000, 8'h00, 0,
                16'h0000, 0, 0, 1, 16'h0000, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1000};
    vecs[8] = '{16'h0211, 8'hFF, 1, 16'h0210, 8'h11, 2, 16'h0000, 8'h00, 0,
                16'hF5A4, 5, 4, 1, 16'h0000, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8};
    reset = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus_we = 1'b1;
      bus_sync = 1'b1;
      bus_addr = (i % 2 == 0) ? 16'h0210 : 16'h0211;
      bus_data = 8'hFF;
      tick();
    end
    bus_we = 1'b0;
    bus_sync = 1'b0;
    check_all_zero("idle");
    for (int k = 0; k < 9; k++) run_case(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    bus_we = 1'b1;
    bus_addr = 16'h0210;
    bus_data = 8'hFF;
    tick();
    bus_we = 1'b0;
    repeat (28) tick();
    check("midrun.cycles", cycles, 29);
    check("midrun.done", done, 0);
    reset = 1'b1;
    tick();
    check_all_zero("midrun_reset");
    reset = 1'b0;
    repeat (3) tick();
    check("post_reset.cycles", cycles, 0);
    check("post_reset.done", done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    bus_we = 1'b1;
    bus_addr = 16'h0211;
    bus_data = 8'hFF;
    tick();
    bus_we = 1'b0;
    repeat (4) tick();
    check("stale.done", done, 0);
    check("stale.pass", pass, 0);
    check("stale.cycles", cycles, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
